// File: rtl/alu_md_pkg.sv
// Shared opcode constants and control-state encoding for the ALU with
// iterative multiply/divide.
package alu_md_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_MULTU = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;
    localparam logic [3:0] OP_MFHI  = 4'd10;
    localparam logic [3:0] OP_MFLO  = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier and restoring divider
// sharing a single working register pair; owns the architectural HI/LO.
module alu_muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] lo_next
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic             run_q, run_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // Multiply keeps the multiplier in work_lo and the multiplicand in opnd;
    // divide keeps the dividend in work_lo (quotient shifts in behind it),
    // the partial remainder in work_hi and the divisor in opnd.
    always_comb begin
        sum     = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? opnd_q : '0)};
        shifted = {work_hi_q, work_lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        step_hi = sum[WIDTH:1];
        step_lo = {sum[0], work_lo_q[WIDTH-1:1]};
        if (div_q) begin
            if (!diff[WIDTH]) begin
                step_hi = diff[WIDTH-1:0];
                step_lo = {work_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = shifted[WIDTH-1:0];
                step_lo = {work_lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign done    = run_q && (cnt_q == LAST);
    assign lo_next = step_lo;
    assign hi      = hi_q;
    assign lo      = lo_q;

    always_comb begin
        run_d     = run_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (start) begin
            run_d     = 1'b1;
            div_d     = op_div;
            cnt_d     = '0;
            opnd_d    = op_div ? b : a;
            work_hi_d = '0;
            work_lo_d = op_div ? a : b;
        end else if (run_q) begin
            work_hi_d = step_hi;
            work_lo_d = step_lo;
            cnt_d     = cnt_q + CNT_W'(1);
            if (done) begin
                run_d = 1'b0;
                cnt_d = '0;
                hi_d  = step_hi;
                lo_d  = step_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= 1'b0;
            div_q     <= 1'b0;
            cnt_q     <= '0;
            opnd_q    <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            run_q     <= run_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: rtl/alu_md.sv
// MIPS-style ALU: single-cycle logic/arith/shift ops plus iterative MULTU/DIVU
// writing HI/LO, with a valid/ready request side and registered result.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             busy
);

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             start;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH-1:0] alu_val;

    assign busy     = (state_q != IDLE);
    assign in_ready = ~busy;
    assign accept   = in_valid & in_ready;
    assign is_mul   = (ALUOperation == OP_MULTU);
    assign is_div   = (ALUOperation == OP_DIVU);
    assign start    = accept & (is_mul | is_div);

    alu_muldiv_iter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_div (is_div),
        .a      (A),
        .b      (B),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .lo_next(lo_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) state_d = MUL;
                if (accept && is_div) state_d = DIV;
            end
            MUL, DIV: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_val = '0;
        case (ALUOperation)
            OP_ADD:  alu_val = A + B;
            OP_SUB:  alu_val = A - B;
            OP_AND:  alu_val = A & B;
            OP_OR:   alu_val = A | B;
            OP_NOR:  alu_val = ~(A | B);
            OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL:  alu_val = A << B[CNT_W-2:0];
            OP_SRL:  alu_val = A >> B[CNT_W-2:0];
            OP_MFHI: alu_val = hi;
            OP_MFLO: alu_val = lo;
            default: alu_val = '0;
        endcase
    end

    // The iterative unit's final LO is forwarded combinationally so the
    // result lands in the same edge that commits HI/LO.
    always_comb begin
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        if (accept && !(is_mul || is_div)) begin
            out_valid_d = 1'b1;
            result_d    = alu_val;
            zero_d      = (alu_val == '0);
        end else if (done) begin
            out_valid_d = 1'b1;
            result_d    = lo_next;
            zero_d      = (lo_next == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed vectors with literal expectations
// plus an arithmetic reference model compared every cycle.
module tb_alu_md;
    import alu_md_pkg::*;

    localparam int WIDTH = 32;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        inValid = 1'b0;
    logic [3:0]  aluOp   = 4'd0;
    logic [31:0] opA     = 32'd0;
    logic [31:0] opB     = 32'd0;
    logic        inReady;
    logic        outValid;
    logic [31:0] aluResult;
    logic        zero;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int validCyc[$];

    alu_md #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (inValid),
        .in_ready    (inReady),
        .ALUOperation(aluOp),
        .A           (opA),
        .B           (opB),
        .out_valid   (outValid),
        .ALUResult   (aluResult),
        .Zero        (zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model: plain arithmetic on whole operands, busy tracked as a
    // countdown of remaining multi-cycle slots.
    function automatic logic [31:0] singleOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] h, input logic [31:0] l);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_MFHI: return h;
            OP_MFLO: return l;
            default: return 32'd0;
        endcase
    endfunction

    int          mRemain = 0;
    logic [31:0] mHi = 0, mLo = 0, mPendHi = 0, mPendLo = 0, mResult = 0;
    logic        mZero = 1'b1, mValid = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mRemain <= 0;
            mHi     <= 0;
            mLo     <= 0;
            mResult <= 0;
            mZero   <= 1'b1;
            mValid  <= 1'b0;
        end else begin
            mValid <= 1'b0;
            if (mRemain > 0) begin
                mRemain <= mRemain - 1;
                if (mRemain == 1) begin
                    mHi     <= mPendHi;
                    mLo     <= mPendLo;
                    mResult <= mPendLo;
                    mZero   <= (mPendLo == 0);
                    mValid  <= 1'b1;
                end
            end else if (inValid) begin
                if (aluOp == OP_MULTU) begin
                    {mPendHi, mPendLo} <= {32'd0, opA} * {32'd0, opB};
                    mRemain <= WIDTH;
                end else if (aluOp == OP_DIVU) begin
                    mPendLo <= (opB == 0) ? 32'hFFFF_FFFF : opA / opB;
                    mPendHi <= (opB == 0) ? opA : opA % opB;
                    mRemain <= WIDTH;
                end else begin
                    mResult <= singleOp(aluOp, opA, opB, mHi, mLo);
                    mZero   <= (singleOp(aluOp, opA, opB, mHi, mLo) == 0);
                    mValid  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("model out_valid", outValid, mValid);
            checkOutput("model busy", busy, mRemain > 0);
            checkOutput("model in_ready", inReady, mRemain == 0);
            checkOutput("model ALUResult", aluResult, mResult);
            checkOutput("model Zero", zero, mZero);
            if (outValid) validCyc.push_back(cycle);
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int waitCnt = 0;
        @(negedge clk);
        inValid = 1'b1;
        aluOp   = op;
        opA     = a;
        opB     = b;
        while (!inReady && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!inReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept op %0d: got in_ready=0 expected in_ready=1 within 200 cycles", op);
            inValid = 1'b0;
        end else begin
            @(posedge clk);
            #1 inValid = 1'b0;
        end
    endtask

    task automatic waitValid(output int lat, output int busyCycles);
        lat = 0;
        busyCycles = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busyCycles++;
        end while (!outValid && lat < 200);
        if (!outValid) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_valid wait: got no pulse expected one within 200 cycles");
        end
    endtask

    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input int expLat);
        int lat, bc;
        applyStimulus(op, a, b);
        waitValid(lat, bc);
        checkOutput({name, " result"}, aluResult, expRes);
        checkOutput({name, " latency"}, lat, expLat);
    endtask

    initial begin
        int lat, bc, nValid;

        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset out_valid", outValid, 1'b0);
        checkOutput("reset ALUResult", aluResult, 32'd0);
        checkOutput("reset Zero", zero, 1'b1);
        checkOutput("reset busy", busy, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        checkOutput("post-reset in_ready", inReady, 1'b1);

        runOp("ADD wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        checkOutput("ADD wrap Zero", zero, 1'b1);
        runOp("SUB 5-7", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        checkOutput("SUB Zero", zero, 1'b0);
        runOp("SLT -1<1", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        runOp("SLL 1<<31", OP_SLL, 32'd1, 32'd31, 32'h8000_0000, 1);
        runOp("SRL >>4", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);

        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        waitValid(lat, bc);
        checkOutput("MULTU LO", aluResult, 32'hFFFF_FFFE);
        checkOutput("MULTU latency", lat, 33);
        checkOutput("MULTU busy cycles", bc, 32);
        runOp("MFHI after MULTU", OP_MFHI, 0, 0, 32'd1, 1);
        runOp("MFLO after MULTU", OP_MFLO, 0, 0, 32'hFFFF_FFFE, 1);

        runOp("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        runOp("MFHI 100%7", OP_MFHI, 0, 0, 32'd2, 1);
        runOp("DIVU 9/0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 33);
        runOp("MFHI 9/0", OP_MFHI, 0, 0, 32'd9, 1);
        runOp("illegal op", 4'd13, 32'h1234, 32'h5678, 32'd0, 1);
        checkOutput("illegal Zero", zero, 1'b1);
        runOp("MFHI after illegal", OP_MFHI, 0, 0, 32'd9, 1);

        // Back-to-back single-cycle traffic; the per-cycle model compare covers it.
        applyStimulus(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        applyStimulus(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
        applyStimulus(OP_NOR, 32'h0000_0000, 32'h0000_0000);
        applyStimulus(OP_SLT, 32'd3, 32'hFFFF_FFFE);
        applyStimulus(OP_SRL, 32'hFFFF_FFFF, 32'd63);
        applyStimulus(OP_SUB, 32'd7, 32'd7);
        applyStimulus(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        applyStimulus(OP_MFHI, 0, 0);
        applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
        applyStimulus(OP_MFHI, 0, 0);
        repeat (3) @(posedge clk);

        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        applyStimulus(OP_ADD, 32'd3, 32'd4);
        waitValid(lat, bc);
        #1;
        checkOutput("held ADD result", aluResult, 32'd7);
        checkOutput("held ADD latency", lat, 1);
        checkOutput("held ADD follows MULTU", validCyc[validCyc.size()-1] - validCyc[validCyc.size()-2], 1);

        applyStimulus(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort out_valid", outValid, 1'b0);
        checkOutput("abort ALUResult", aluResult, 32'd0);
        checkOutput("abort Zero", zero, 1'b1);
        checkOutput("abort busy", busy, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        nValid = validCyc.size();
        repeat (40) @(posedge clk);
        checkOutput("abort no out_valid", validCyc.size(), nValid);
        runOp("MFLO after abort", OP_MFLO, 0, 0, 32'd0, 1);
        runOp("MFHI after abort", OP_MFHI, 0, 0, 32'd0, 1);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
